// File: rtl/mirfak_pkg.sv
// Shared definitions for the mirfak iterative divider: command and state encodings
// plus small decode helpers.
package mirfak_pkg;

    // div_cmd encodings, matching funct3[1:0] of the RV32M divide group
    typedef enum logic [1:0] {
        CMD_DIV  = 2'b00,
        CMD_DIVU = 2'b01,
        CMD_REM  = 2'b10,
        CMD_REMU = 2'b11
    } div_cmd_e;

    // Divider sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    localparam int unsigned DIV_W    = 32;
    localparam int unsigned CNT_W    = 5;
    localparam logic [CNT_W-1:0] LAST_ITER = 5'd31;

    // Signed commands are the even encodings
    function automatic logic cmd_is_signed(input div_cmd_e cmd);
        return (cmd == CMD_DIV) || (cmd == CMD_REM);
    endfunction

    // Remainder commands have bit 1 set
    function automatic logic cmd_wants_rem(input div_cmd_e cmd);
        return (cmd == CMD_REM) || (cmd == CMD_REMU);
    endfunction

    // Unsigned magnitude; |0x80000000| wraps back to 0x80000000, which is the
    // correct unsigned magnitude
    function automatic logic [DIV_W-1:0] magnitude(input logic [DIV_W-1:0] v,
                                                   input logic             sgn);
        return (sgn && v[DIV_W-1]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mirfak_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Operands are reduced to magnitudes on entry, 32 quotient bits are produced
// one per cycle, and signs are reapplied in the DONE cycle. Fixed latency:
// enable sampled at edge 0, ack/result visible after edge 33.
module mirfak_divider
    import mirfak_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] div_op1,
    input  logic [31:0] div_op2,
    input  logic [1:0]  div_cmd,
    input  logic        div_enable,
    output logic [31:0] div_result,
    output logic        div_ack
);

    div_state_e        state_q, state_d;
    div_cmd_e          cmd_q, cmd_d;
    logic [31:0]       dvs_q, dvs_d;      // divisor magnitude
    logic [31:0]       quo_q, quo_d;      // dividend shifting out / quotient shifting in
    logic [31:0]       rem_q, rem_d;      // partial remainder, always < divisor
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       result_q, result_d;
    logic              ack_q, ack_d;

    logic              req_signed;
    logic [32:0]       shifted;
    logic [32:0]       trial;

    // Next-state, datapath step and result formation
    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d   = state_q;
        cmd_d     = cmd_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        ack_d     = 1'b0;

        req_signed = ~div_cmd[0];
        // The remainder is kept below the divisor, so the shifted value fits in 33 bits
        // and its top bit is zero whenever the trial subtraction fails.
        shifted    = {rem_q, quo_q[31]};
        trial      = shifted - {1'b0, dvs_q};

        unique case (state_q)
            ST_IDLE: begin
                // The enable still seen in the ack cycle belongs to the finished request
                if (div_enable && !ack_q) begin
                    cmd_d     = div_cmd_e'(div_cmd);
                    quo_d     = magnitude(div_op1, req_signed);
                    dvs_d     = magnitude(div_op2, req_signed);
                    neg_quo_d = req_signed & (div_op1[31] ^ div_op2[31]) & (div_op2 != 32'd0);
                    neg_rem_d = req_signed & div_op1[31];
                    rem_d     = 32'd0;
                    cnt_d     = '0;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = shifted[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (cmd_wants_rem(cmd_q)) begin
                    result_d = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
                end else begin
                    result_d = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
                end
                ack_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            // NOTE: the datapath registers are reset too; they are few and it keeps simulation X-free.
            state_q   <= ST_IDLE;
            cmd_q     <= CMD_DIV;
            dvs_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            dvs_q     <= dvs_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            ack_q     <= ack_d;
        end
    end

    assign div_result = result_q;
    assign div_ack    = ack_q;

endmodule

// File: tb/tb_mirfak_divider.sv
// Self-checking bench for mirfak_divider: an arithmetic reference model plus
// hand-computed literals, checked by one compare process on every falling edge.
module tb_mirfak_divider;
    import mirfak_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic [1:0]  div_cmd;
    logic        div_enable;
    logic [31:0] div_result;
    logic        div_ack;

    mirfak_divider dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .div_op1    (div_op1),
        .div_op2    (div_op2),
        .div_cmd    (div_cmd),
        .div_enable (div_enable),
        .div_result (div_result),
        .div_ack    (div_ack)
    );

    always #5 clk_i = ~clk_i;

    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic        checking = 1'b0;
    logic        pending = 1'b0;
    int          ack_at = 0;
    logic [31:0] exp_model = '0;
    logic [31:0] exp_lit = '0;
    logic [31:0] last_res = '0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", name, cyc, actual, expected);
        end
    endtask

    // Reference: RV32M semantics from plain arithmetic
    function automatic logic [31:0] model(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               rem;
        logic               sgn;
        sa  = a;
        sb  = b;
        rem = cmd[1];
        sgn = ~cmd[0];
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : a;
        if (sgn) return rem ? 32'(sa % sb) : 32'(sa / sb);
        return rem ? (a % b) : (a / b);
    endfunction

    // Compare process: ack timing, result on ack, result held otherwise
    always @(negedge clk_i) begin
        if (checking) begin
            logic exp_ack;
            exp_ack = pending && (cyc == ack_at);
            check("ack", {31'd0, div_ack}, {31'd0, exp_ack});
            if (exp_ack) begin
                check("result_model", div_result, exp_model);
                check("result_literal", div_result, exp_lit);
                last_res = exp_model;
                pending  = 1'b0;
            end else begin
                check("result_hold", div_result, last_res);
            end
        end
    end

    // Advance past the next rising edge; inputs change well away from both edges
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic run_op(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit, input logic scramble, input logic hold);
        div_cmd    = cmd;
        div_op1    = a;
        div_op2    = b;
        div_enable = 1'b1;
        tick();                       // enable sampled at this edge (edge 0)
        exp_model = model(cmd, a, b);
        exp_lit   = lit;
        ack_at    = cyc + 33;
        pending   = 1'b1;
        if (scramble) begin
            div_op1 = 32'd0;
            div_op2 = 32'd0;
            div_cmd = 2'b10;
        end
        repeat (33) tick();           // now inside the ack cycle
        if (hold) tick();             // enable still high at the edge ending the ack cycle
        div_enable = 1'b0;
        tick();
    endtask

    initial begin
        rst_i      = 1'b1;
        div_enable = 1'b0;
        div_op1    = '0;
        div_op2    = '0;
        div_cmd    = 2'b00;
        tick();
        tick();
        rst_i    = 1'b0;
        last_res = 32'd0;
        checking = 1'b1;
        check("reset_result", div_result, 32'd0);
        check("reset_ack", {31'd0, div_ack}, 32'd0);
        tick();

        run_op(2'b00, 32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, 1'b0, 1'b0);
        run_op(2'b10, 32'd20,         32'hFFFF_FFFD, 32'h0000_0002, 1'b0, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF, 1'b0, 1'b0);
        run_op(2'b11, 32'hFFFF_FFFF,  32'd2,         32'h0000_0001, 1'b0, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(2'b00, 32'h8000_0000,  32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(2'b01, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1'b0, 1'b0);
        run_op(2'b11, 32'd5,          32'd0,         32'h0000_0005, 1'b0, 1'b0);
        run_op(2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
        run_op(2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
        run_op(2'b11, 32'd7,          32'd100,       32'h0000_0007, 1'b0, 1'b0);
        run_op(2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF6, 32'h0000_000A, 1'b0, 1'b0);

        // Handshake: enable held through the ack cycle, operands scrambled during BUSY
        run_op(2'b01, 32'd100,        32'd7,         32'd14,        1'b1, 1'b1);
        // A spurious second request would ack within this window
        repeat (40) tick();

        // Reset after 10 BUSY iterations aborts with no ack
        div_cmd    = 2'b01;
        div_op1    = 32'd1000;
        div_op2    = 32'd3;
        div_enable = 1'b1;
        tick();
        repeat (10) tick();
        rst_i      = 1'b1;
        div_enable = 1'b0;
        tick();
        rst_i    = 1'b0;
        last_res = 32'd0;
        repeat (40) tick();

        run_op(2'b00, 32'hFFFF_FF9C,  32'd10,        32'hFFFF_FFF6, 1'b0, 1'b0);
        tick();

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mirfak_divider.md
Name: mirfak_divider

Overview:
Iterative 32-bit divider implementing the RV32M DIV, DIVU, REM and REMU operations. It is the inverse-operation companion of the fast multiplier and sits beside it in the execute stage with the same pipeline handshake: operands plus command in, result plus one-cycle ack out. It uses a radix-2 restoring algorithm (one quotient bit per cycle) with sign pre/post-correction. This keeps area small at the cost of fixed multi-cycle latency.

Parameters:
None. Width is fixed at 32 bits.

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset; synchronous, active-high
div_op1  input  32  dividend (rs1)
div_op2  input  32  divisor (rs2)
div_cmd  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
div_enable  input  1  request; held high by pipeline until ack
div_result  output  32  quotient or remainder; valid in the ack cycle
div_ack  output  1  single-cycle completion pulse

Behaviour:
- Decode: is_signed = ~div_cmd[0]; want_rem = div_cmd[1].
- Reset (rst_i high at a clock edge):
  - State goes to IDLE; div_ack = 0; div_result = 0; counter = 0.
  - Reset mid-operation aborts with no ack; the next request behaves normally.
- States: IDLE -> BUSY -> DONE -> IDLE.
- IDLE, div_enable = 1 at an edge:
  - Latch cmd.
  - Latch |op1| and |op2| as 32-bit unsigned magnitudes (absolute value only when is_signed and the MSB is set; |0x80000000| = 0x80000000).
  - Latch neg_q = is_signed & (op1[31] ^ op2[31]) & (op2 != 0).
  - Latch neg_r = is_signed & op1[31].
  - Clear the 33-bit partial remainder; load the dividend magnitude into the quotient shift register; counter = 0; go to BUSY.
- BUSY, each edge:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor magnitude from the rem (33-bit).
  - If non-negative, keep the difference and set quo[0] = 1; else restore and set quo[0] = 0.
  - counter += 1; after the 32nd iteration go to DONE.
- DONE, one edge:
  - div_result = want_rem ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo).
  - div_ack = 1; go to IDLE.
- Ack cycle:
  - div_ack is high for exactly one cycle and is cleared on the following edge.
  - div_enable sampled in the ack cycle is ignored; the pipeline deasserts it after seeing the ack.
- Latency: enable sampled at edge 0; div_ack and div_result are visible in the cycle after edge 33, i.e. 34 cycles after the enable cycle. Latency is fixed and independent of operand values.
- Operand and command inputs are don't-care outside the IDLE sampling edge. Changes during BUSY must not affect the result.
- div_result holds its last value until the next DONE or reset.
- Boundary: divide by zero
  - The algorithm naturally yields quo = 0xFFFFFFFF and rem = |op1|.
  - neg_q is forced 0, so DIV/DIVU return 0xFFFFFFFF.
  - neg_r restores the sign, so REM/REMU return op1 unchanged.
- Boundary: signed overflow (0x80000000 / 0xFFFFFFFF)
  - Magnitudes are 0x80000000 / 1; neg_q = 0.
  - Result is quotient 0x80000000, remainder 0. No special-case logic is needed.
- Negation is two's complement modulo 2^32.

Decomposition:
- Shared package (mirfak defines): the div_cmd encodings (DIV, DIVU, REM, REMU) and the divider state encodings.
- No sub-module is required. The datapath (shift, trial subtract, counter) and the FSM fit one module of roughly 150-200 lines.

Test Plan:
- DIV 20 / 0xFFFFFFFD (-3) -> div_result 0xFFFFFFFA (-6); REM same operands -> 0x00000002.
- DIVU 0xFFFFFFFF / 2 -> 0x7FFFFFFF; REMU same operands -> 0x00000001; REM 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFF (-1).
- Divide by zero: DIV 0x80000000 / 0 -> 0xFFFFFFFF; DIVU 5 / 0 -> 0xFFFFFFFF; REM 0xFFFFFFF9 / 0 -> 0xFFFFFFF9; REMU 5 / 0 -> 5.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0x00000000.
- Handshake: hold enable high with DIVU 100 / 7.
  - div_ack is high in cycle 34 only, with result 14.
  - Operands changed to 0/0 during BUSY do not alter the result.
  - Enable held through the ack cycle does not start a second operation until it is resampled in IDLE.
- Reset at BUSY iteration 10: no ack is ever produced, div_result = 0. A following DIV 0xFFFFFF9C (-100) / 10 -> 0xFFFFFFF6 after 34 cycles.
